// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Raster timing generator for a VGA-style display. A pixel column counter
//   (hpos) and line counter (vpos) advance on pixel-enable cycles. Two phase
//   FSMs (horizontal and vertical) track ACTIVE/FRONT/SYNC/BACK regions.
//   Every output is registered and refers to the same raster position.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          synchronous active-high reset
//   en           pixel advance enable
//   hpos/vpos    current pixel column / line
//   display_on   position is inside the visible area
//   hsync/vsync  sync pulses, active level chosen by SYNC_NEG
//   hphase/vphase  phase state (0 ACTIVE, 1 FRONT, 2 SYNC, 3 BACK)
//   line_start   one-clk strobe on the first pixel of a line
//   frame_start  one-clk strobe on the first pixel of a frame
//   frame_cnt    frame counter, modulo 256
//
// state     | meaning
// ----------+-----------------------------------------
// PH_ACTIVE | visible pixels / lines
// PH_FRONT  | front porch
// PH_SYNC   | sync pulse
// PH_BACK   | back porch (also the reset state)
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int SYNC_NEG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] hphase,
  output logic [1:0] vphase,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_B1   = 10'(H_ACTIVE);
  localparam logic [9:0] H_B2   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_B3   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_B1   = 10'(V_ACTIVE);
  localparam logic [9:0] V_B2   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_B3   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_ACT = (SYNC_NEG != 0) ? 1'b0 : 1'b1;

  // Region lookup for the position being entered; zero-width regions are
  // never returned, so a porch of 0 is skipped with no cycle spent in it.
  function automatic phase_e phase_at(input logic [9:0] p, input logic [9:0] b1,
                                      input logic [9:0] b2, input logic [9:0] b3);
    if (p < b1)      return PH_ACTIVE;
    else if (p < b2) return PH_FRONT;
    else if (p < b3) return PH_SYNC;
    else             return PH_BACK;
  endfunction

  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  phase_e     hphase_q, hphase_d, vphase_q, vphase_d;
  logic       display_q, display_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       line_q, line_d, frame_q, frame_d;
  logic [7:0] fcnt_q, fcnt_d;

  logic       h_wrap, v_wrap, v_step;
  logic [9:0] h_next, v_next;

  assign h_wrap = (hpos_q == H_LAST);
  assign v_wrap = (vpos_q == V_LAST);
  assign h_next = h_wrap ? 10'd0 : hpos_q + 10'd1;
  assign v_next = v_wrap ? 10'd0 : vpos_q + 10'd1;
  assign v_step = en & h_wrap;

  always_comb begin
    hpos_d   = hpos_q;
    vpos_d   = vpos_q;
    hphase_d = hphase_q;
    vphase_d = vphase_q;
    if (en) begin
      hpos_d = h_next;
      // A wrap ends whatever region is current (covers a zero back porch).
      unique case (hphase_q)
        PH_ACTIVE: if (h_next == H_B1 || h_wrap) hphase_d = phase_at(h_next, H_B1, H_B2, H_B3);
        PH_FRONT:  if (h_next == H_B2 || h_wrap) hphase_d = phase_at(h_next, H_B1, H_B2, H_B3);
        PH_SYNC:   if (h_next == H_B3 || h_wrap) hphase_d = phase_at(h_next, H_B1, H_B2, H_B3);
        PH_BACK:   if (h_wrap)                   hphase_d = phase_at(h_next, H_B1, H_B2, H_B3);
        default:   hphase_d = PH_BACK;
      endcase
    end
    if (v_step) begin
      vpos_d = v_next;
      unique case (vphase_q)
        PH_ACTIVE: if (v_next == V_B1 || v_wrap) vphase_d = phase_at(v_next, V_B1, V_B2, V_B3);
        PH_FRONT:  if (v_next == V_B2 || v_wrap) vphase_d = phase_at(v_next, V_B1, V_B2, V_B3);
        PH_SYNC:   if (v_next == V_B3 || v_wrap) vphase_d = phase_at(v_next, V_B1, V_B2, V_B3);
        PH_BACK:   if (v_wrap)                   vphase_d = phase_at(v_next, V_B1, V_B2, V_B3);
        default:   vphase_d = PH_BACK;
      endcase
    end
  end

  // Derived outputs follow the next phase so they line up with hpos/vpos;
  // with en=0 the phases hold, so these hold too.
  always_comb begin
    display_d = (hphase_d == PH_ACTIVE) && (vphase_d == PH_ACTIVE);
    hsync_d   = (hphase_d == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d   = (vphase_d == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    line_d    = v_step;
    frame_d   = v_step & v_wrap;
    fcnt_d    = frame_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q    <= H_LAST;
      vpos_q    <= V_LAST;
      hphase_q  <= PH_BACK;
      vphase_q  <= PH_BACK;
      display_q <= 1'b0;
      hsync_q   <= ~SYNC_ACT;
      vsync_q   <= ~SYNC_ACT;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      fcnt_q    <= 8'hFF;
    end else begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      hphase_q  <= hphase_d;
      vphase_q  <= vphase_d;
      display_q <= display_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hphase      = hphase_q;
  assign vphase      = vphase_q;
  assign display_on  = display_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  // d_*: default timing; v_*: SYNC_NEG=0, H_FRONT=0; s_*: tiny raster
  logic [9:0] d_hpos, d_vpos, v_hpos, v_vpos, s_hpos, s_vpos;
  logic       d_disp, d_hs, d_vs, d_ls, d_fs;
  logic       v_disp, v_hs, v_vs, v_ls, v_fs;
  logic       s_disp, s_hs, s_vs, s_ls, s_fs;
  logic [1:0] d_hph, d_vph, v_hph, v_vph, s_hph, s_vph;
  logic [7:0] d_fc, v_fc, s_fc;

  vga_timing_ctrl u_def (
    .clk(clk), .rst(rst), .en(en), .hpos(d_hpos), .vpos(d_vpos),
    .display_on(d_disp), .hsync(d_hs), .vsync(d_vs), .hphase(d_hph),
    .vphase(d_vph), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
  );

  vga_timing_ctrl #(.SYNC_NEG(0), .H_FRONT(0)) u_pos (
    .clk(clk), .rst(rst), .en(en), .hpos(v_hpos), .vpos(v_vpos),
    .display_on(v_disp), .hsync(v_hs), .vsync(v_vs), .hphase(v_hph),
    .vphase(v_vph), .line_start(v_ls), .frame_start(v_fs), .frame_cnt(v_fc)
  );

  // 8+2+3+1 = 14 pixels, 4+1+2+1 = 8 lines, 112 pixels per frame
  vga_timing_ctrl #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_small (
    .clk(clk), .rst(rst), .en(en), .hpos(s_hpos), .vpos(s_vpos),
    .display_on(s_disp), .hsync(s_hs), .vsync(s_vs), .hphase(s_hph),
    .vphase(s_vph), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   hs_fall, hs_rise, vh_cnt, vh_min, vh_max;
  int   cnt, ls_cnt, vs_cnt, vmin, vmax, disp_cnt, changes, run, max_run;
  logic prev_hs, found;
  logic [9:0] prev_h;

  initial begin
    // reset state
    tick(); tick();
    check("rst_hpos", d_hpos, 799);
    check("rst_vpos", d_vpos, 524);
    check("rst_hphase", d_hph, 3);
    check("rst_vphase", d_vph, 3);
    check("rst_disp", d_disp, 0);
    check("rst_hsync", d_hs, 1);
    check("rst_vsync", d_vs, 1);
    check("rst_ls", d_ls, 0);
    check("rst_fs", d_fs, 0);
    check("rst_fc", d_fc, 255);
    check("rst_pos_hsync", v_hs, 0);
    check("rst_small_hpos", s_hpos, 13);

    // first enabled cycle
    rst = 1'b0; en = 1'b1;
    tick();
    check("first_hpos", d_hpos, 0);
    check("first_vpos", d_vpos, 0);
    check("first_disp", d_disp, 1);
    check("first_ls", d_ls, 1);
    check("first_fs", d_fs, 1);
    check("first_fc", d_fc, 0);
    check("first_hphase", d_hph, 0);

    // sweep the first line
    hs_fall = -1; hs_rise = -1; vh_cnt = 0; vh_min = 1023; vh_max = -1;
    prev_hs = d_hs;
    for (int i = 1; i < 800; i++) begin
      tick();
      if (prev_hs && !d_hs) hs_fall = int'(d_hpos);
      if (!prev_hs && d_hs) hs_rise = int'(d_hpos);
      prev_hs = d_hs;
      if (d_hpos == 10'd1)   check("ls_clear", d_ls, 0);
      if (d_hpos == 10'd640) check("hph_front_640", d_hph, 1);
      if (d_hpos == 10'd656) check("hph_sync_656", d_hph, 2);
      if (d_hpos == 10'd752) check("hph_back_752", d_hph, 3);
      if (v_hpos == 10'd639) check("pos_hph_639", v_hph, 0);
      if (v_hpos == 10'd640) check("pos_hph_640", v_hph, 2);
      if (v_hs) begin
        vh_cnt++;
        if (int'(v_hpos) < vh_min) vh_min = int'(v_hpos);
        if (int'(v_hpos) > vh_max) vh_max = int'(v_hpos);
      end
    end
    check("hsync_fall", hs_fall, 656);
    check("hsync_rise", hs_rise, 752);
    check("pos_hsync_len", vh_cnt, 96);
    check("pos_hsync_min", vh_min, 640);
    check("pos_hsync_max", vh_max, 735);
    check("line_end_hpos", d_hpos, 799);

    tick();
    check("line2_hpos", d_hpos, 0);
    check("line2_vpos", d_vpos, 1);
    check("line2_ls", d_ls, 1);
    check("line2_fs", d_fs, 0);

    // reset mid-frame
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (d_hpos == 10'd300) found = 1'b1;
    end
    check("reach_300", found, 1);
    check("mid_vpos", d_vpos, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_hpos", d_hpos, 799);
    check("mid_rst_vpos", d_vpos, 524);
    check("mid_rst_disp", d_disp, 0);
    check("mid_rst_fc", d_fc, 255);
    check("mid_rst_ls", d_ls, 0);
    check("mid_rst_fs", d_fs, 0);
    check("mid_rst_hsync", d_hs, 1);

    // small raster: one full frame with continuous enable
    rst = 1'b0; en = 1'b1;
    tick();
    check("s_first_fs", s_fs, 1);
    check("s_first_fc", s_fc, 0);
    cnt = 0; ls_cnt = 1; vs_cnt = 0; vmin = 1023; vmax = -1; disp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      cnt++;
      if (s_fs) break;
      if (s_ls) ls_cnt++;
      if (s_disp) disp_cnt++;
      if (!s_vs) begin
        vs_cnt++;
        if (int'(s_vpos) < vmin) vmin = int'(s_vpos);
        if (int'(s_vpos) > vmax) vmax = int'(s_vpos);
      end
    end
    check("s_frame_period", cnt, 112);
    check("s_line_pulses", ls_cnt, 8);
    check("s_disp_cycles", disp_cnt, 32);
    check("s_vsync_cycles", vs_cnt, 28);
    check("s_vsync_min", vmin, 5);
    check("s_vsync_max", vmax, 6);
    check("s_fs_ls", s_ls, 1);
    check("s_fc_1", s_fc, 1);

    // toggle enable every clock
    cnt = 0; changes = 0; run = 0; max_run = 0; prev_h = s_hpos;
    for (int k = 0; k < 1000; k++) begin
      en = k[0];
      tick();
      cnt++;
      if (k == 0) begin
        check("hold_ls", s_ls, 0);
        check("hold_fs", s_fs, 0);
        check("hold_hpos", s_hpos, 0);
      end
      if (s_hpos != prev_h) changes++;
      prev_h = s_hpos;
      if (s_ls) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (s_fs) break;
    end
    check("tog_period", cnt, 224);
    check("tog_hpos_steps", changes, 112);
    check("tog_strobe_len", max_run, 1);
    check("tog_fc", s_fc, 2);

    // frame counter wrap from 255
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      tick();
      if (s_fc == 8'd255 && s_hpos == 10'd13 && s_vpos == 10'd7) found = 1'b1;
    end
    check("reach_fc255_end", found, 1);
    tick();
    check("wrap_hpos", s_hpos, 0);
    check("wrap_vpos", s_vpos, 0);
    check("wrap_ls", s_ls, 1);
    check("wrap_fs", s_fs, 1);
    check("wrap_fc", s_fc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
